// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter.
// Runs the request-to-send handshake, shifts out data/parity/stop on
// device-generated clock falls, checks the device ack, then waits for idle.
module ps2_host_tx #(
  parameter int FILTER_CYCLES  = 16,
  parameter int INHIBIT_CYCLES = 5000,
  parameter int START_TIMEOUT  = 750000,
  parameter int XFER_TIMEOUT   = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error,
  inout  wire logic  ps2_clk,
  inout  wire logic  ps2_data
);

  localparam int MAX_A = (INHIBIT_CYCLES > START_TIMEOUT) ? INHIBIT_CYCLES : START_TIMEOUT;
  localparam int MAX_T = (MAX_A > XFER_TIMEOUT) ? MAX_A : XFER_TIMEOUT;
  localparam int CW    = $clog2(MAX_T + 1);
  localparam int FW    = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;

  localparam logic [CW-1:0] INH_LAST   = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] START_LAST = CW'(START_TIMEOUT - 1);
  localparam logic [CW-1:0] XFER_LAST  = CW'(XFER_TIMEOUT - 1);
  localparam logic [FW-1:0] FLT_LAST   = FW'(FILTER_CYCLES - 1);

  localparam logic [3:0] IDLE       = 4'd0;
  localparam logic [3:0] INHIBIT    = 4'd1;
  localparam logic [3:0] REQ        = 4'd2;
  localparam logic [3:0] WAIT_START = 4'd3;
  localparam logic [3:0] SHIFT      = 4'd4;
  localparam logic [3:0] ACK        = 4'd5;
  localparam logic [3:0] WAIT_IDLE  = 4'd6;
  localparam logic [3:0] DONE       = 4'd7;
  localparam logic [3:0] FAIL       = 4'd8;

  logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic          r_clk_f, r_clk_fd;
  logic [FW-1:0] r_fcnt;
  logic [3:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_shreg;
  logic          r_par;
  logic [3:0]    r_bitcnt;
  logic          r_data_oe;
  logic          w_fall;
  logic          w_clk_oe;
  logic          w_data_oe;

  // Two-flop synchronizers for both open-drain lines
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= ps2_data;
      r_dat_s2 <= r_dat_s1;
    end
  end

  // Glitch filter: follow the synchronized clock only after it has differed
  // for FILTER_CYCLES consecutive cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_f  <= 1'b1;
      r_clk_fd <= 1'b1;
      r_fcnt   <= '0;
    end else begin
      r_clk_fd <= r_clk_f;
      if (r_clk_s2 == r_clk_f) begin
        r_fcnt <= '0;
      end else if (r_fcnt == FLT_LAST) begin
        r_clk_f <= r_clk_s2;
        r_fcnt  <= '0;
      end else begin
        r_fcnt <= r_fcnt + 1'b1;
      end
    end
  end

  assign w_fall = r_clk_fd & ~r_clk_f;

  // Transfer FSM; cnt restarts on each state entry but runs on through
  // SHIFT, ACK and WAIT_IDLE so it bounds the whole byte transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_shreg   <= '0;
      r_par     <= 1'b0;
      r_bitcnt  <= '0;
      r_data_oe <= 1'b0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
      case (r_state)
        IDLE: begin
          r_cnt     <= '0;
          r_data_oe <= 1'b0;
          if (tx_valid) begin
            r_shreg  <= tx_data;
            r_par    <= ~^tx_data;
            r_bitcnt <= '0;
            r_state  <= INHIBIT;
          end
        end
        INHIBIT: begin
          if (r_cnt == INH_LAST) begin
            r_cnt     <= '0;
            r_data_oe <= 1'b1;
            r_state   <= REQ;
          end
        end
        REQ: begin
          r_cnt   <= '0;
          r_state <= WAIT_START;
        end
        WAIT_START: begin
          if (r_cnt == START_LAST) begin
            r_cnt   <= '0;
            r_state <= FAIL;
          end else if (w_fall) begin
            r_data_oe <= ~r_shreg[0];
            r_shreg   <= {1'b0, r_shreg[7:1]};
            r_bitcnt  <= 4'd1;
            r_cnt     <= '0;
            r_state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (r_cnt == XFER_LAST) begin
            r_cnt   <= '0;
            r_state <= FAIL;
          end else if (w_fall) begin
            r_bitcnt <= r_bitcnt + 1'b1;
            if (r_bitcnt <= 4'd7) begin
              r_data_oe <= ~r_shreg[0];
              r_shreg   <= {1'b0, r_shreg[7:1]};
            end else if (r_bitcnt == 4'd8) begin
              r_data_oe <= ~r_par;
            end else begin
              r_data_oe <= 1'b0;
              r_state   <= ACK;
            end
          end
        end
        ACK: begin
          if (r_cnt == XFER_LAST) begin
            r_cnt   <= '0;
            r_state <= FAIL;
          end else if (w_fall) begin
            r_state <= r_dat_s2 ? FAIL : WAIT_IDLE;
            if (r_dat_s2) r_cnt <= '0;
          end
        end
        WAIT_IDLE: begin
          if (r_cnt == XFER_LAST) begin
            r_cnt   <= '0;
            r_state <= FAIL;
          end else if (r_clk_f && r_dat_s2) begin
            r_cnt   <= '0;
            r_state <= DONE;
          end
        end
        DONE, FAIL: begin
          r_cnt     <= '0;
          r_data_oe <= 1'b0;
          r_state   <= IDLE;
        end
        default: begin
          r_cnt     <= '0;
          r_data_oe <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

  // Data is only ever driven from the start bit through the stop bit
  assign w_clk_oe  = (r_state == INHIBIT) || (r_state == REQ);
  assign w_data_oe = r_data_oe && ((r_state == REQ) || (r_state == WAIT_START) ||
                                   (r_state == SHIFT) || (r_state == ACK));

  assign ps2_clk  = w_clk_oe  ? 1'b0 : 1'bz;
  assign ps2_data = w_data_oe ? 1'b0 : 1'bz;

  assign tx_ready = (r_state == IDLE);
  assign busy     = ~tx_ready;
  assign tx_done  = (r_state == DONE);
  assign tx_error = (r_state == FAIL);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a simple PS/2 device model.
module tb_ps2_host_tx;

  localparam int HALF = 40;

  logic       clk;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, busy, tx_done, tx_error;
  logic       dev_clk_low, dev_data_low;
  wire        ps2_clk, ps2_data;

  int total = 0;
  int bad   = 0;
  int n_done = 0;
  int n_err  = 0;
  int n_both = 0;

  pullup (ps2_clk);
  pullup (ps2_data);
  assign ps2_clk  = dev_clk_low  ? 1'b0 : 1'bz;
  assign ps2_data = dev_data_low ? 1'b0 : 1'bz;

  ps2_host_tx #(
    .FILTER_CYCLES (2),
    .INHIBIT_CYCLES(20),
    .START_TIMEOUT (500),
    .XFER_TIMEOUT  (2000)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .busy    (busy),
    .tx_done (tx_done),
    .tx_error(tx_error),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse monitor
  always @(negedge clk) begin
    if (tx_done) n_done <= n_done + 1;
    if (tx_error) n_err <= n_err + 1;
    if (tx_done && tx_error) n_both <= n_both + 1;
  end

  // Wait for the host's start bit with the clock released
  task automatic wait_rts(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ps2_clk === 1'b1 && ps2_data === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL rts_wait: start bit not seen within 300 cycles");
    end
  endtask

  // Device clocks 11 edges; samp[i] = line value before rising edge i+1
  task automatic dev_run(input logic ack, output logic [9:0] samp);
    bit ok;
    samp = '0;
    wait_rts(ok);
    repeat (10) @(negedge clk);
    for (int k = 1; k <= 11; k++) begin
      if (k == 11 && ack) dev_data_low = 1'b1;
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      if (k <= 10) samp[k-1] = ps2_data;
      dev_clk_low = 1'b0;
      repeat (HALF) @(negedge clk);
      if (k == 11) dev_data_low = 1'b0;
    end
  endtask

  task automatic wait_end(input int d0, input int e0);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (n_done != d0 || n_err != e0) begin
        seen = 1'b1;
        break;
      end
    end
    repeat (3) @(posedge clk);
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL end_wait: no done/error pulse within 200 cycles");
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    total += 6;
    if (tx_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", tx_ready); end
    if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    if (tx_done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", tx_done); end
    if (tx_error !== 1'b0) begin bad++; $display("FAIL rst_error: got %b want 0", tx_error); end
    if (ps2_clk !== 1'b1) begin bad++; $display("FAIL rst_clk: got %b want 1", ps2_clk); end
    if (ps2_data !== 1'b1) begin bad++; $display("FAIL rst_data: got %b want 1", ps2_data); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_send_ed;
    logic [9:0] s;
    int d0, e0;
    d0 = n_done; e0 = n_err;
    send(8'hED);
    dev_run(1'b1, s);
    wait_end(d0, e0);
    total += 4;
    if (s !== 10'h3ED) begin bad++; $display("FAIL ed_bits: got %h want 3ed", s); end
    if (n_done - d0 !== 1) begin bad++; $display("FAIL ed_done: got %0d want 1", n_done - d0); end
    if (n_err - e0 !== 0) begin bad++; $display("FAIL ed_err: got %0d want 0", n_err - e0); end
    if (tx_ready !== 1'b1) begin bad++; $display("FAIL ed_ready: got %b want 1", tx_ready); end
  endtask

  task automatic test_send_f4;
    logic [9:0] s;
    int d0, e0, inh;
    bit hit;
    d0 = n_done; e0 = n_err;
    inh = 0; hit = 1'b0;
    @(negedge clk);
    tx_data  = 8'hF4;
    tx_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      tx_valid = 1'b0;
      if (ps2_clk === 1'b0 && ps2_data === 1'b1) inh++;
      else if (ps2_clk === 1'b0 && ps2_data === 1'b0) begin hit = 1'b1; break; end
    end
    total += 2;
    if (!hit) begin bad++; $display("FAIL f4_req: data-low cycle not seen"); end
    if (inh !== 20) begin bad++; $display("FAIL f4_inhibit: got %0d want 20", inh); end
    dev_run(1'b1, s);
    wait_end(d0, e0);
    total += 3;
    if (s[8] !== 1'b0) begin bad++; $display("FAIL f4_parity: got %b want 0", s[8]); end
    if (s !== 10'h2F4) begin bad++; $display("FAIL f4_bits: got %h want 2f4", s); end
    if (n_done - d0 !== 1) begin bad++; $display("FAIL f4_done: got %0d want 1", n_done - d0); end
  endtask

  task automatic test_start_timeout;
    bit ok, seen;
    int n, d0;
    d0 = n_done;
    n = 0; seen = 1'b0;
    send(8'h12);
    wait_rts(ok);
    n = 1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (tx_error === 1'b1) begin seen = 1'b1; break; end
      n++;
    end
    total += 4;
    if (!seen) begin bad++; $display("FAIL to_seen: no error pulse within 1000 cycles"); end
    if (n !== 500) begin bad++; $display("FAIL to_cycles: got %0d want 500", n); end
    if (ps2_clk !== 1'b1 || ps2_data !== 1'b1) begin
      bad++; $display("FAIL to_lines: got clk=%b data=%b want 1 1", ps2_clk, ps2_data);
    end
    @(negedge clk);
    if (tx_ready !== 1'b1) begin bad++; $display("FAIL to_ready: got %b want 1", tx_ready); end
    repeat (3) @(posedge clk);
    total++;
    if (n_done !== d0) begin bad++; $display("FAIL to_nodone: got %0d want %0d", n_done, d0); end
  endtask

  task automatic test_nack;
    logic [9:0] s;
    int d0, e0;
    d0 = n_done; e0 = n_err;
    send(8'hF4);
    dev_run(1'b0, s);
    repeat (5) @(posedge clk);
    total += 3;
    if (n_err - e0 !== 1) begin bad++; $display("FAIL nack_err: got %0d want 1", n_err - e0); end
    if (n_done - d0 !== 0) begin bad++; $display("FAIL nack_done: got %0d want 0", n_done - d0); end
    if (tx_ready !== 1'b1) begin bad++; $display("FAIL nack_ready: got %b want 1", tx_ready); end
  endtask

  task automatic test_rst_mid;
    bit ok;
    logic [9:0] s;
    int d0, e0;
    d0 = n_done; e0 = n_err;
    send(8'h55);
    wait_rts(ok);
    repeat (10) @(negedge clk);
    for (int k = 1; k <= 3; k++) begin
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (HALF) @(negedge clk);
    end
    dev_clk_low = 1'b1;
    repeat (10) @(negedge clk);
    total++;
    if (ps2_data !== 1'b0) begin bad++; $display("FAIL mid_bit3: got %b want 0", ps2_data); end
    dev_clk_low = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total += 3;
    if (ps2_clk !== 1'b1) begin bad++; $display("FAIL mid_clk: got %b want 1", ps2_clk); end
    if (ps2_data !== 1'b1) begin bad++; $display("FAIL mid_data: got %b want 1", ps2_data); end
    if (tx_ready !== 1'b1) begin bad++; $display("FAIL mid_ready: got %b want 1", tx_ready); end
    repeat (50) @(posedge clk);
    total += 2;
    if (n_done !== d0) begin bad++; $display("FAIL mid_done: got %0d want %0d", n_done, d0); end
    if (n_err !== e0) begin bad++; $display("FAIL mid_err: got %0d want %0d", n_err, e0); end
    send(8'hFF);
    dev_run(1'b1, s);
    wait_end(d0, e0);
    total += 2;
    if (s !== 10'h3FF) begin bad++; $display("FAIL ff_bits: got %h want 3ff", s); end
    if (n_done - d0 !== 1) begin bad++; $display("FAIL ff_done: got %0d want 1", n_done - d0); end
  endtask

  task automatic test_back_to_back;
    logic [9:0] s;
    int d0, e0;
    bit rdy;
    d0 = n_done; e0 = n_err;
    @(negedge clk);
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_data  = 8'h3C;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy: got %b want 1", busy); end
    dev_run(1'b1, s);
    total++;
    if (s !== 10'h3A5) begin bad++; $display("FAIL b2b_first: got %h want 3a5", s); end
    rdy = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (tx_ready === 1'b1) begin rdy = 1'b1; break; end
      @(negedge clk);
    end
    total++;
    if (!rdy) begin bad++; $display("FAIL b2b_ready: tx_ready not seen within 200 cycles"); end
    @(negedge clk);
    tx_valid = 1'b0;
    total += 2;
    if (n_done - d0 !== 1) begin bad++; $display("FAIL b2b_done1: got %0d want 1", n_done - d0); end
    if (tx_ready !== 1'b0) begin bad++; $display("FAIL b2b_accept2: got ready=%b want 0", tx_ready); end
    dev_run(1'b1, s);
    wait_end(d0 + 1, e0);
    total += 3;
    if (s !== 10'h33C) begin bad++; $display("FAIL b2b_second: got %h want 33c", s); end
    if (n_done - d0 !== 2) begin bad++; $display("FAIL b2b_done2: got %0d want 2", n_done - d0); end
    if (n_err - e0 !== 0) begin bad++; $display("FAIL b2b_err: got %0d want 0", n_err - e0); end
  endtask

  task automatic test_exclusive;
    total++;
    if (n_both !== 0) begin bad++; $display("FAIL excl: done&error together %0d times want 0", n_both); end
  endtask

  initial begin
    rst          = 1'b1;
    tx_data      = '0;
    tx_valid     = 1'b0;
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    test_reset;
    test_send_ed;
    test_send_f4;
    test_start_timeout;
    test_nack;
    test_rst_mid;
    test_back_to_back;
    test_exclusive;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
